mc_ctrl: RTL and testbench
==========================

// Module: mc_ctrl
// PURPOSE
//  Multi-cycle control FSM for the MIPS datapath: sequences fetch/decode/execute/mem/writeback over one shared
//  ALU and one unified instruction/data memory port with a ready handshake. Replaces the combinational control
//  unit when the datapath gains IR, A/B, ALUOut and MDR registers. Drives all datapath strobes/selects; flags
//  illegal opcodes and memory timeouts by halting.
// PARAMETERS
//  TIMEOUT  16  max consecutive cycles mem_req may wait for mem_ready before halt; 0 = wait forever
// PORTS
//  clk          in   1  clock, rising edge
//  reset        in   1  synchronous, active-low (reset==0 resets on the clk edge)
//  opcode       in   6  IR[31:26], stable from DECODE until the next FETCH
//  funct        in   6  IR[5:0]
//  zero         in   1  ALU zero flag (same cycle)
//  mem_ready    in   1  memory completes the access this cycle; may be combinational from mem_req
//  mem_req      out  1  memory access request
//  mem_we       out  1  write strobe, qualified by mem_req
//  mem_sel_data out  1  0 = address from PC (fetch), 1 = address from ALUOut
//  mem_byte     out  1  byte access (lb/sb)
//  ir_write     out  1  load IR
//  pc_write     out  1  load PC
//  pc_src       out  2  0 ALU result, 1 ALUOut (branch target), 2 {PC[31:28],IR[25:0],2'b00}, 3 A (rs)
//  reg_write    out  1  GRF write enable
//  reg_dst      out  2  0 rt, 1 rd, 2 $31
//  mem_to_reg   out  2  0 ALUOut, 1 MDR, 2 PC
//  alu_src_a    out  1  0 PC, 1 A
//  alu_src_b    out  2  0 B, 1 const 4, 2 ext(imm), 3 ext(imm)<<2
//  ext_ctrl     out  2  0 zero, 1 sign, 2 upper (imm<<16)
//  alu_op       out  5  0 ADD, 1 SUB, 2 OR, 3 LUI
//  halted       out  1  FSM in HALT
//  err_code     out  2  0 none, 1 illegal instr, 2 mem timeout; sticky until reset
// BEHAVIOUR
//  - Supported: addu subu ori lui lw sw lb sb beq j jal jr; all-zero word = nop. Others -> illegal.
//  - Reset: state<=FETCH, wait counter<=0, err_code<=0. While reset==0 every strobe
//    (mem_req, mem_we, ir_write, pc_write, reg_write) is forced 0 combinationally. Reset mid-access aborts it.
//  - Outputs combinational from state+opcode/funct; pc_write/ir_write also from zero/mem_ready. Unlisted = 0.
//  - FETCH: mem_req, sel_data=0, a=PC, b=4, ADD. On mem_ready: ir_write, pc_write, pc_src=0 -> DECODE; else stay.
//  - DECODE: a=PC, b=imm<<2, sign, ADD (branch target -> ALUOut). Next: nop->FETCH; R addu/subu->EXEC_R;
//    jr->JR; ori/lui->EXEC_I; lw/lb/sw/sb->MEM_ADDR; beq->BRANCH; j/jal->JUMP; else err=1 -> HALT.
//  - EXEC_R: a=A, b=B, ADD/SUB by funct -> WB_ALU. EXEC_I: a=A, b=imm, ori zero-ext OR, lui upper LUI -> WB_ALU.
//  - WB_ALU: reg_write, reg_dst=rd(R)/rt(I), mem_to_reg=0 -> FETCH.
//  - MEM_ADDR: a=A, b=imm sign, ADD -> MEM_RD (loads) / MEM_WR (stores).
//  - MEM_RD: mem_req, sel_data=1, mem_byte for lb; on mem_ready -> MEM_WB. MEM_WB: reg_write, rt, mem_to_reg=1 -> FETCH.
//  - MEM_WR: mem_req, mem_we, sel_data=1, mem_byte for sb; on mem_ready -> FETCH.
//  - BRANCH: a=A, b=B, SUB; pc_write=zero, pc_src=1 -> FETCH.
//  - JUMP: pc_write, pc_src=2; jal also reg_write, reg_dst=2, mem_to_reg=2 (PC already PC+4) -> FETCH.
//  - JR: pc_write, pc_src=3 -> FETCH.
//  - HALT: all strobes 0, halted=1; leave only via reset.
//  - Latency at zero wait: nop 2, beq/j/jal/jr 3, R/I/sw/sb 4, lw/lb 5 cycles; +1 per mem_ready-low cycle.
//  - Wait counter: +1 each cycle mem_req&&!mem_ready, cleared when mem_ready or state leaves the access.
//    Counter==TIMEOUT-1 with mem_ready still 0 -> err=2, HALT next edge. mem_ready on that cycle wins.
//  - Illegal and timeout never coincide (different states); err_code never overwritten once non-zero.
// STRUCTURE
//  - mc_defs.vh (shared): state codes, opcode/funct constants, ALU_*, EXT_*, PCSRC_*, RDST_*, M2R_*, ERR_*.
//  - Sub-module mc_mem_wait: wait counter + timeout compare (inputs req, ready, clear; output timeout).
//  - Top: state register, next-state case, output decode case.
// TESTING
//  - reset=0 for 2 cycles mid-MEM_RD -> strobes 0 during reset; FETCH, err_code=0 after release.
//  - addu (op 0, funct 0x21), mem_ready=1 -> 4 cycles; WB_ALU: reg_write=1, reg_dst=1, alu_op=0 in EXEC_R.
//  - lw, mem_ready low 3 cycles in MEM_RD -> 8 cycles total; MEM_WB: mem_to_reg=1, reg_dst=0.
//  - beq zero=1 then zero=0 -> pc_write=1 / 0 in BRANCH, pc_src=1; both 3 cycles.
//  - jal -> JUMP with pc_write=1, pc_src=2, reg_write=1, reg_dst=2, mem_to_reg=2; opcode 0x3F -> HALT, err=1.
//  - TIMEOUT=16, mem_ready stuck 0 in FETCH -> HALT after 16 cycles, err_code=2; ready on cycle 16 -> DECODE.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: state codes,
// opcode/funct constants, datapath select encodings and the decode helper.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_WB_ALU,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP,
    S_JR,
    S_HALT
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_NOP  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_OR  = 5'd2;
  localparam logic [4:0] ALU_LUI = 5'd3;

  localparam logic [1:0] EXT_ZERO  = 2'd0;
  localparam logic [1:0] EXT_SIGN  = 2'd1;
  localparam logic [1:0] EXT_UPPER = 2'd2;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_REG    = 2'd3;

  localparam logic [1:0] RDST_RT = 2'd0;
  localparam logic [1:0] RDST_RD = 2'd1;
  localparam logic [1:0] RDST_RA = 2'd2;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MDR = 2'd1;
  localparam logic [1:0] M2R_PC  = 2'd2;

  localparam logic ASRC_PC = 1'b0;
  localparam logic ASRC_A  = 1'b1;

  localparam logic [1:0] BSRC_B      = 2'd0;
  localparam logic [1:0] BSRC_FOUR   = 2'd1;
  localparam logic [1:0] BSRC_IMM    = 2'd2;
  localparam logic [1:0] BSRC_IMM_SH = 2'd3;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  // Successor of DECODE; an unsupported encoding maps to HALT.
  function automatic state_e decode_next(input logic [5:0] op, input logic [5:0] fn);
    state_e nxt;
    nxt = S_HALT;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_NOP:           nxt = S_FETCH;
          FN_ADDU, FN_SUBU: nxt = S_EXEC_R;
          FN_JR:            nxt = S_JR;
          default:          nxt = S_HALT;
        endcase
      end
      OP_ORI, OP_LUI:               nxt = S_EXEC_I;
      OP_LW, OP_LB, OP_SW, OP_SB:   nxt = S_MEM_ADDR;
      OP_BEQ:                       nxt = S_BRANCH;
      OP_J, OP_JAL:                 nxt = S_JUMP;
      default:                      nxt = S_HALT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mc_mem_wait.sv
// Memory wait counter: counts consecutive stalled request cycles and flags
// a timeout on the last allowed stall cycle.
module mc_mem_wait #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic req_i,
  input  logic ready_i,
  input  logic clear_i,
  output logic timeout_o
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // TIMEOUT of zero disables the limit entirely.
  assign timeout_o = (TIMEOUT != 0) && req_i && !ready_i && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || ready_i || !req_i) begin
      cnt_d = '0;
    end else if ((TIMEOUT != 0) && !timeout_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/mem/writeback
// over a shared ALU and unified memory port, halting on illegal ops or timeouts.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_sel_data,
  output logic       mem_byte,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] ext_ctrl,
  output logic [4:0] alu_op,
  output logic       halted,
  output logic [1:0] err_code
);

  state_e     state_q, state_d;
  logic [1:0] err_q, err_d;
  logic       acc_state;
  logic       timeout;
  logic       req_raw, we_raw, irw_raw, pcw_raw, rw_raw;

  assign acc_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

  mc_mem_wait #(.TIMEOUT(TIMEOUT)) u_wait (
    .clk       (clk),
    .reset     (reset),
    .req_i     (acc_state),
    .ready_i   (mem_ready),
    .clear_i   (!acc_state),
    .timeout_o (timeout)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // The first error recorded is kept; later conditions cannot overwrite it.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
                  else if (timeout) state_d = S_HALT;
      S_DECODE:   state_d = decode_next(opcode, funct);
      S_EXEC_R,
      S_EXEC_I:   state_d = S_WB_ALU;
      S_MEM_ADDR: state_d = ((opcode == OP_LW) || (opcode == OP_LB)) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
                  else if (timeout) state_d = S_HALT;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
                  else if (timeout) state_d = S_HALT;
      S_WB_ALU,
      S_MEM_WB,
      S_BRANCH,
      S_JUMP,
      S_JR:       state_d = S_FETCH;
      default:    state_d = S_HALT;
    endcase
    if (err_q == ERR_NONE) begin
      if ((state_q == S_DECODE) && (state_d == S_HALT)) begin
        err_d = ERR_ILLEGAL;
      end else if (timeout) begin
        err_d = ERR_TIMEOUT;
      end
    end
  end

  always_comb begin
    req_raw      = 1'b0;
    we_raw       = 1'b0;
    irw_raw      = 1'b0;
    pcw_raw      = 1'b0;
    rw_raw       = 1'b0;
    mem_sel_data = 1'b0;
    mem_byte     = 1'b0;
    pc_src       = PCSRC_ALU;
    reg_dst      = RDST_RT;
    mem_to_reg   = M2R_ALU;
    alu_src_a    = ASRC_PC;
    alu_src_b    = BSRC_B;
    ext_ctrl     = EXT_ZERO;
    alu_op       = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        req_raw   = 1'b1;
        alu_src_b = BSRC_FOUR;
        irw_raw   = mem_ready;
        pcw_raw   = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = BSRC_IMM_SH;
        ext_ctrl  = EXT_SIGN;
      end
      S_EXEC_R: begin
        alu_src_a = ASRC_A;
        alu_op    = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
      end
      S_EXEC_I: begin
        alu_src_a = ASRC_A;
        alu_src_b = BSRC_IMM;
        ext_ctrl  = (opcode == OP_LUI) ? EXT_UPPER : EXT_ZERO;
        alu_op    = (opcode == OP_LUI) ? ALU_LUI : ALU_OR;
      end
      S_WB_ALU: begin
        rw_raw  = 1'b1;
        reg_dst = (opcode == OP_RTYPE) ? RDST_RD : RDST_RT;
      end
      S_MEM_ADDR: begin
        alu_src_a = ASRC_A;
        alu_src_b = BSRC_IMM;
        ext_ctrl  = EXT_SIGN;
      end
      S_MEM_RD: begin
        req_raw      = 1'b1;
        mem_sel_data = 1'b1;
        mem_byte     = (opcode == OP_LB);
      end
      S_MEM_WB: begin
        rw_raw     = 1'b1;
        mem_to_reg = M2R_MDR;
      end
      S_MEM_WR: begin
        req_raw      = 1'b1;
        we_raw       = 1'b1;
        mem_sel_data = 1'b1;
        mem_byte     = (opcode == OP_SB);
      end
      S_BRANCH: begin
        alu_src_a = ASRC_A;
        alu_op    = ALU_SUB;
        pcw_raw   = zero;
        pc_src    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        pcw_raw = 1'b1;
        pc_src  = PCSRC_JUMP;
        if (opcode == OP_JAL) begin
          rw_raw     = 1'b1;
          reg_dst    = RDST_RA;
          mem_to_reg = M2R_PC;
        end
      end
      S_JR: begin
        pcw_raw = 1'b1;
        pc_src  = PCSRC_REG;
      end
      default: ;
    endcase
  end

  // Strobes are gated by reset so an in-flight access is dropped immediately.
  assign mem_req   = reset & req_raw;
  assign mem_we    = reset & we_raw;
  assign ir_write  = reset & irw_raw;
  assign pc_write  = reset & pcw_raw;
  assign reg_write = reset & rw_raw;
  assign halted    = (state_q == S_HALT);
  assign err_code  = err_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed reset/halt/timeout steps plus
// randomized instructions scored against an instruction-level model.
module tb_mc_ctrl;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, mem_sel_data, mem_byte, ir_write, pc_write;
  logic [1:0] pc_src;
  logic       reg_write;
  logic [1:0] reg_dst, mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b, ext_ctrl;
  logic [4:0] alu_op;
  logic       halted;
  logic [1:0] err_code;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       ir, pcw, rw, req, sel, we, mb;
    logic [1:0] pcs, rdst, m2r, ext;
    logic [4:0] aop;
  } obs_t;

  obs_t rec[64];

  mc_ctrl #(.TIMEOUT(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .funct        (funct),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_sel_data (mem_sel_data),
    .mem_byte     (mem_byte),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .reg_write    (reg_write),
    .reg_dst      (reg_dst),
    .mem_to_reg   (mem_to_reg),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .ext_ctrl     (ext_ctrl),
    .alu_op       (alu_op),
    .halted       (halted),
    .err_code     (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle and present mem_ready for it.
  task automatic applyStimulus(input logic rdy);
    @(negedge clk);
    mem_ready = rdy;
    #1;
  endtask

  // Instruction-level reference: cycle counts and visible effects per instruction.
  function automatic int baseLatency(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00 && fn == 6'h00) return 2;
    if (op == 6'h00 && fn == 6'h08) return 3;
    if (op == 6'h04 || op == 6'h02 || op == 6'h03) return 3;
    if (op == 6'h23 || op == 6'h20) return 5;
    return 4;
  endfunction

  // Runs one instruction starting in its fetch cycle; returns at the next fetch.
  task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                          input int fw, input int dw);
    int  c, fLeft, dLeft, expLat, expPcw, expRw;
    int  irN, pcwN, rwN, weN, dreqN, mbN;
    bit  done, prevFetch, isFetch;
    bit  isLoad, isStore, isR, isI, isJmp;
    opcode = op; funct = fn; zero = z;
    fLeft = fw; dLeft = dw;
    c = 0; done = 0; prevFetch = 1;
    while (!done && c < 40) begin
      isFetch = mem_req && !mem_sel_data;
      if (c > 0 && isFetch && !prevFetch) begin
        done = 1;
      end else begin
        c++;
        if (mem_req && !mem_sel_data) begin
          mem_ready = (fLeft == 0);
          if (fLeft > 0) fLeft--;
        end else if (mem_req) begin
          mem_ready = (dLeft == 0);
          if (dLeft > 0) dLeft--;
        end else begin
          mem_ready = 1'b0;
        end
        #1;
        rec[c].ir  = ir_write;  rec[c].pcw = pc_write; rec[c].rw  = reg_write;
        rec[c].req = mem_req;   rec[c].sel = mem_sel_data;
        rec[c].we  = mem_we;    rec[c].mb  = mem_byte;
        rec[c].pcs = pc_src;    rec[c].rdst = reg_dst; rec[c].m2r = mem_to_reg;
        rec[c].ext = ext_ctrl;  rec[c].aop = alu_op;
        prevFetch = isFetch;
        @(negedge clk);
      end
    end
    mem_ready = 1'b0;

    isLoad  = (op == 6'h23 || op == 6'h20);
    isStore = (op == 6'h2B || op == 6'h28);
    isR     = (op == 6'h00 && (fn == 6'h21 || fn == 6'h23));
    isI     = (op == 6'h0D || op == 6'h0F);
    isJmp   = (op == 6'h02 || op == 6'h03 || (op == 6'h00 && fn == 6'h08));
    expLat  = baseLatency(op, fn) + fw + ((isLoad || isStore) ? dw : 0);
    expPcw  = 1 + ((isJmp || (op == 6'h04 && z)) ? 1 : 0);
    expRw   = (isLoad || isR || isI || op == 6'h03) ? 1 : 0;

    checkOutput("instrDone", 32'(done), 1);
    checkOutput("latency", c, expLat);
    irN = 0; pcwN = 0; rwN = 0; weN = 0; dreqN = 0; mbN = 0;
    for (int i = 1; i <= c; i++) begin
      irN  += int'(rec[i].ir);
      pcwN += int'(rec[i].pcw);
      rwN  += int'(rec[i].rw);
      weN  += int'(rec[i].we);
      if (rec[i].req && rec[i].sel) begin
        dreqN++;
        mbN += int'(rec[i].mb);
      end
    end
    checkOutput("irWrites", irN, 1);
    if (fw + 1 <= c) checkOutput("irAtReady", 32'(rec[fw + 1].ir), 1);
    checkOutput("pcWrites", pcwN, expPcw);
    checkOutput("regWrites", rwN, expRw);
    checkOutput("memWrites", weN, isStore ? dw + 1 : 0);
    checkOutput("dataReqs", dreqN, (isLoad || isStore) ? dw + 1 : 0);
    checkOutput("byteCycles", mbN, (op == 6'h20 || op == 6'h28) ? dw + 1 : 0);
    checkOutput("errNone", 32'(err_code), 0);
    if (c >= 2) begin
      if (expRw == 1) begin
        checkOutput("wbRegWrite", 32'(rec[c].rw), 1);
        checkOutput("wbRegDst", 32'(rec[c].rdst), isR ? 1 : (op == 6'h03 ? 2 : 0));
        checkOutput("wbMemToReg", 32'(rec[c].m2r), isLoad ? 1 : (op == 6'h03 ? 2 : 0));
      end
      if (isR) checkOutput("execAluR", 32'(rec[c - 1].aop), (fn == 6'h23) ? 1 : 0);
      if (isI) begin
        checkOutput("execAluI", 32'(rec[c - 1].aop), (op == 6'h0F) ? 3 : 2);
        checkOutput("execExtI", 32'(rec[c - 1].ext), (op == 6'h0F) ? 2 : 0);
      end
      if (op == 6'h04) begin
        checkOutput("beqPcWrite", 32'(rec[c].pcw), 32'(z));
        checkOutput("beqPcSrc", 32'(rec[c].pcs), 1);
        checkOutput("beqAluSub", 32'(rec[c].aop), 1);
      end
      if (isJmp) checkOutput("jumpPcSrc", 32'(rec[c].pcs), (op == 6'h00) ? 3 : 2);
    end
  endtask

  logic [5:0] tabOp[12];
  logic [5:0] tabFn[12];

  initial begin
    int k;
    tabOp = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h20, 6'h2B, 6'h28, 6'h04, 6'h02};
    tabFn = '{6'h00, 6'h21, 6'h23, 6'h08, 6'h15, 6'h3A, 6'h01, 6'h22, 6'h10, 6'h05, 6'h11, 6'h07};
    reset = 1'b0; opcode = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b0;

    // Reset state: strobes forced low even with ready asserted.
    applyStimulus(1'b1);
    checkOutput("rstMemReq", 32'(mem_req), 0);
    checkOutput("rstIrWrite", 32'(ir_write), 0);
    checkOutput("rstPcWrite", 32'(pc_write), 0);
    applyStimulus(1'b0);
    reset = 1'b1;
    #1;
    checkOutput("relFetchReq", 32'(mem_req), 1);
    checkOutput("relFetchSel", 32'(mem_sel_data), 0);
    checkOutput("relErr", 32'(err_code), 0);
    checkOutput("relHalted", 32'(halted), 0);

    // Reset asserted for two cycles in the middle of a stalled load.
    opcode = 6'h23; funct = 6'h00;
    mem_ready = 1'b1;
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    checkOutput("mrdReq", 32'(mem_req), 1);
    checkOutput("mrdSel", 32'(mem_sel_data), 1);
    reset = 1'b0;
    #1;
    checkOutput("abortReq", 32'(mem_req), 0);
    applyStimulus(1'b1);
    checkOutput("abortReqHeld", 32'(mem_req), 0);
    checkOutput("abortRegWrite", 32'(reg_write), 0);
    applyStimulus(1'b0);
    reset = 1'b1;
    #1;
    checkOutput("abortFetchReq", 32'(mem_req), 1);
    checkOutput("abortFetchSel", 32'(mem_sel_data), 0);
    checkOutput("abortErr", 32'(err_code), 0);

    // Directed instructions.
    runInstr(6'h00, 6'h21, 1'b0, 0, 0);
    runInstr(6'h23, 6'h00, 1'b0, 0, 3);
    runInstr(6'h04, 6'h00, 1'b1, 0, 0);
    runInstr(6'h04, 6'h00, 1'b0, 0, 0);
    runInstr(6'h03, 6'h00, 1'b0, 0, 0);
    runInstr(6'h00, 6'h00, 1'b0, 2, 0);

    // Randomized instruction stream with random memory stalls.
    for (int n = 0; n < 40; n++) begin
      k = int'($urandom_range(0, 11));
      runInstr(tabOp[k], tabFn[k], 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Illegal opcode halts with error 1.
    opcode = 6'h3F; funct = 6'h00;
    mem_ready = 1'b1;
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    checkOutput("illHalted", 32'(halted), 1);
    checkOutput("illErr", 32'(err_code), 1);
    checkOutput("illReq", 32'(mem_req), 0);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    checkOutput("illStaysHalted", 32'(halted), 1);
    checkOutput("illErrSticky", 32'(err_code), 1);
    checkOutput("illNoPcWrite", 32'(pc_write), 0);

    // Fetch timeout: ready stuck low for 16 cycles.
    opcode = 6'h00; funct = 6'h00;
    reset = 1'b0;
    applyStimulus(1'b0);
    reset = 1'b1;
    #1;
    checkOutput("clrErr", 32'(err_code), 0);
    for (int i = 0; i < 15; i++) applyStimulus(1'b0);
    checkOutput("tmo15Halted", 32'(halted), 0);
    checkOutput("tmo15Req", 32'(mem_req), 1);
    applyStimulus(1'b0);
    checkOutput("tmoHalted", 32'(halted), 1);
    checkOutput("tmoErr", 32'(err_code), 2);
    applyStimulus(1'b1);
    checkOutput("tmoErrSticky", 32'(err_code), 2);
    checkOutput("tmoReqOff", 32'(mem_req), 0);

    // Ready arriving on the last allowed stall cycle wins over the timeout.
    reset = 1'b0;
    applyStimulus(1'b0);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 15; i++) applyStimulus(1'b0);
    mem_ready = 1'b1;
    #1;
    checkOutput("lateReadyIr", 32'(ir_write), 1);
    applyStimulus(1'b0);
    checkOutput("lateReadyHalted", 32'(halted), 0);
    checkOutput("lateReadyErr", 32'(err_code), 0);
    checkOutput("lateReadyDecode", 32'(mem_req), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
